// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit framing controller driving a downstream field mux.
// Define UART_TX_CTRL_PARITY_EN to include the parity field; otherwise PAR_EN/PAR_TYP are ignored.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, next_state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  accept, last, par_path;

    assign accept = (state == IDLE) && Data_Valid;
    assign last   = cnt == CW'(DATA_WIDTH - 1);

`ifdef UART_TX_CTRL_PARITY_EN
    logic en_q, typ_q;

    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            en_q  <= 1'b0;
            typ_q <= 1'b0;
        end else if (accept) begin
            en_q  <= PAR_EN;
            typ_q <= PAR_TYP;
        end

    assign par_path = en_q;
    assign par_bit  = ^data_q ^ typ_q;
`else
    logic unused_par;

    assign unused_par = PAR_EN ^ PAR_TYP;
    assign par_path   = 1'b0;
    assign par_bit    = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST)
        if (!RST) state <= IDLE;
        else      state <= next_state;

    // Counter idles at 0 so it is already cleared when DATA begins
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            cnt    <= '0;
            data_q <= '0;
        end else begin
            cnt <= (state == DATA) ? cnt + 1'b1 : '0;
            if (accept) data_q <= P_DATA;
        end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = Data_Valid ? START : IDLE;
            START:   next_state = DATA;
            DATA:    next_state = last ? (par_path ? PARITY : STOP) : DATA;
            PARITY:  next_state = STOP;
            STOP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mux_sel  = (state == START) ? 2'b00 :
                   (state == DATA)  ? 2'b01 :
                   (state == PARITY) ? 2'b10 : 2'b11;
        busy     = state != IDLE;
        ser_data = (state == DATA) && data_q[cnt];
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: table-driven and randomized checks of uart_tx_ctrl against a field-sequence model.
module tb_uart_tx_ctrl;
    localparam int W = 8;
`ifdef UART_TX_CTRL_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [W-1:0] P_DATA = '0;
    logic         Data_Valid = 1'b0;
    logic         PAR_EN = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic [1:0]   mux_sel;
    logic         ser_data, par_bit, busy;

    uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .mux_sel(mux_sel),
        .ser_data(ser_data), .par_bit(par_bit), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] mux;
        logic       busy;
        logic       ser;
        logic       ser_chk;
        logic       par;
        logic       par_chk;
    } samp_t;

    typedef struct {
        logic [W-1:0] d;
        logic         en;
        logic         typ;
        int           len;
        logic         par;
    } vec_t;

    samp_t exp_q[$];
    vec_t  vecs[6];
    int    checks = 0;
    int    failures = 0;
    int    obs_len;
    logic  first_par;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle fields: start, W payload bits LSB first, optional parity, stop
    task automatic push_frame(input logic [W-1:0] d, input logic en, input logic typ);
        logic p;
        p = PAR_ON ? (^d ^ typ) : 1'b0;
        exp_q.push_back('{2'b00, 1'b1, 1'b0, 1'b0, p, 1'b1});
        for (int k = 0; k < W; k++) exp_q.push_back('{2'b01, 1'b1, d[k], 1'b1, p, 1'b1});
        if (PAR_ON && en) exp_q.push_back('{2'b10, 1'b1, 1'b0, 1'b0, p, 1'b1});
        exp_q.push_back('{2'b11, 1'b1, 1'b0, 1'b0, p, 1'b1});
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic check_run(input string name);
        obs_len = 0;
        first_par = par_bit;
        foreach (exp_q[i]) begin
            check({name, " mux_sel"}, 32'(mux_sel), 32'(exp_q[i].mux));
            check({name, " busy"}, 32'(busy), 32'(exp_q[i].busy));
            if (exp_q[i].ser_chk) check({name, " ser_data"}, 32'(ser_data), 32'(exp_q[i].ser));
            if (exp_q[i].par_chk) check({name, " par_bit"}, 32'(par_bit), 32'(exp_q[i].par));
            if (busy) obs_len++;
            @(negedge CLK);
        end
        exp_q.delete();
    endtask

    task automatic start_frame(input logic [W-1:0] d, input logic en, input logic typ);
        P_DATA = d;
        PAR_EN = en;
        PAR_TYP = typ;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        P_DATA = ~d;
        PAR_EN = ~en;
        PAR_TYP = ~typ;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, PAR_ON ? 11 : 10, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, PAR_ON ? 11 : 10, PAR_ON};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 10, 1'b0};
        vecs[3] = '{8'h01, 1'b1, 1'b1, PAR_ON ? 11 : 10, 1'b0};
        vecs[4] = '{8'hFE, 1'b1, 1'b0, PAR_ON ? 11 : 10, PAR_ON};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 10, PAR_ON};

        @(negedge CLK);
        @(negedge CLK);
        check("reset mux_sel", 32'(mux_sel), 32'h3);
        check("reset busy", 32'(busy), 32'h0);
        check("reset ser_data", 32'(ser_data), 32'h0);
        check("reset par_bit", 32'(par_bit), 32'h0);
        RST = 1'b1;

        foreach (vecs[i]) begin
            start_frame(vecs[i].d, vecs[i].en, vecs[i].typ);
            push_frame(vecs[i].d, vecs[i].en, vecs[i].typ);
            push_idle(1);
            check_run($sformatf("vec%0d", i));
            check($sformatf("vec%0d len", i), 32'(obs_len), 32'(vecs[i].len));
            check($sformatf("vec%0d par", i), 32'(first_par), 32'(vecs[i].par));
        end

        // Data_Valid held high: second frame starts after exactly one idle cycle
        P_DATA = 8'h01;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        Data_Valid = 1'b1;
        @(negedge CLK);
        P_DATA = 8'hFF;
        push_frame(8'h01, 1'b1, 1'b0);
        push_idle(1);
        check_run("b2b first");
        Data_Valid = 1'b0;
        push_frame(8'hFF, 1'b1, 1'b0);
        push_idle(2);
        check_run("b2b second");

        // Reset in the 4th DATA cycle aborts the frame
        start_frame(8'hA5, 1'b1, 1'b0);
        push_frame(8'hA5, 1'b1, 1'b0);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        check_run("pre_rst");
        check("in 4th data", 32'(mux_sel), 32'h1);
        RST = 1'b0;
        #1;
        check("async rst mux_sel", 32'(mux_sel), 32'h3);
        check("async rst busy", 32'(busy), 32'h0);
        check("async rst ser_data", 32'(ser_data), 32'h0);
        check("async rst par_bit", 32'(par_bit), 32'h0);
        @(negedge CLK);
        check("held rst busy", 32'(busy), 32'h0);
        RST = 1'b1;
        push_idle(4);
        check_run("post_rst");

        for (int n = 0; n < 20; n++) begin
            logic [W-1:0] d;
            logic en, typ;
            d = W'($urandom);
            en = 1'($urandom);
            typ = 1'($urandom);
            start_frame(d, en, typ);
            push_frame(d, en, typ);
            push_idle(1 + int'($urandom_range(0, 2)));
            check_run($sformatf("rand%0d", n));
            check($sformatf("rand%0d len", n), 32'(obs_len), 32'(W + 2 + ((PAR_ON && en) ? 1 : 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
